// File: rtl/regex_cpu_pipe.sv
// Regex execution pipeline: SELECT -> FETCH -> WAIT -> EXEC, with an internal FIFO for SPLIT/JMP threads.
// Optional: define REGEX_CPU_ACCEPT_PARTIAL_EN so that ACCEPT_PARTIAL accepts regardless of end of string.
module regex_cpu_pipe #(
    parameter int PC_WIDTH              = 9,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int MEMORY_WIDTH          = 20,
    parameter int MEMORY_ADDR_WIDTH     = 11,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2,
    parameter int CC_ID_BITS            = 2,
    localparam int NCC                  = 2 ** CC_ID_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NCC*CHARACTER_WIDTH-1:0] current_characters,
    input  logic [NCC-1:0]                 end_of_string,
    input  logic                           input_pc_valid,
    output logic                           input_pc_ready,
    input  logic [PC_WIDTH-1:0]            input_pc,
    input  logic [CC_ID_BITS-1:0]          input_cc_id,
    output logic                           memory_valid,
    input  logic                           memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]   memory_addr,
    input  logic [MEMORY_WIDTH-1:0]        memory_data,
    output logic                           output_pc_valid,
    input  logic                           output_pc_ready,
    output logic [PC_WIDTH-1:0]            output_pc,
    output logic [CC_ID_BITS-1:0]          output_cc_id,
    output logic                           accepts,
    output logic [NCC-1:0]                 elaborating_chars,
    output logic                           running
);
    localparam int INSTRUCTION_DATA_WIDTH = 17;
    localparam int FW    = FIFO_WIDTH_POWER_OF_2;
    localparam int DEPTH = 2 ** FW;
    localparam logic [FW-1:0]       PTR_ONE = FW'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

    typedef enum logic [2:0] {
        OP_ACCEPT = 3'd0, OP_SPLIT = 3'd1, OP_MATCH = 3'd2, OP_NOT_MATCH = 3'd3,
        OP_MATCH_ANY = 3'd4, OP_JMP = 3'd5, OP_END = 3'd6, OP_ACCEPT_PARTIAL = 3'd7
    } opcode_e;

    logic ready_en_q, ready_en_d;
    logic fetch_valid_q, fetch_valid_d, wait_valid_q, wait_valid_d, exec_valid_q, exec_valid_d;
    logic out_valid_q, out_valid_d, accepts_q, accepts_d, wait_has_data_q, wait_has_data_d;
    logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d, wait_pc_q, wait_pc_d, exec_pc_q, exec_pc_d, out_pc_q, out_pc_d;
    logic [CC_ID_BITS-1:0]   fetch_cc_q, fetch_cc_d, wait_cc_q, wait_cc_d, exec_cc_q, exec_cc_d, out_cc_q, out_cc_d;
    logic [MEMORY_WIDTH-1:0] wait_instr_q, wait_instr_d, exec_instr_q, exec_instr_d, wait_word;
    logic [PC_WIDTH+CC_ID_BITS-1:0] fifo_mem_q [DEPTH];
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_offs;
    logic [FW:0]   fifo_cnt_q, fifo_cnt_d;

    logic mem_hs, fifo_pop, wait_to_exec, exec_free, exec_fire, exec_stall, exec_eos;
    logic exec_do_out, exec_do_acc;
    logic [1:0] exec_push_n, push_cnt;
    logic [PC_WIDTH-1:0] push_pc_a, push_pc_b, exec_payload_pc;
    logic [CHARACTER_WIDTH-1:0] exec_char;
    opcode_e exec_op;

    assign memory_valid    = fetch_valid_q && !wait_valid_q;
    assign mem_hs          = memory_valid && memory_ready;
    assign memory_addr     = MEMORY_ADDR_WIDTH'(fetch_pc_q);
    assign input_pc_ready  = ready_en_q && !fetch_valid_q && (fifo_cnt_q == '0);
    assign output_pc_valid = out_valid_q;
    assign output_pc       = out_pc_q;
    assign output_cc_id    = out_cc_q;
    assign accepts         = accepts_q;
    assign ready_en_d      = 1'b1;

    // SELECT: FIFO threads take priority over new threads; FETCH holds until the handshake.
    always_comb begin
        fifo_pop      = 1'b0;
        fetch_valid_d = fetch_valid_q && !mem_hs;
        fetch_pc_d    = fetch_pc_q;
        fetch_cc_d    = fetch_cc_q;
        if (!fetch_valid_q) begin
            if (fifo_cnt_q != '0) begin
                fifo_pop      = 1'b1;
                fetch_valid_d = 1'b1;
                {fetch_pc_d, fetch_cc_d} = fifo_mem_q[rd_ptr_q];
            end else if (input_pc_valid && input_pc_ready) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = input_pc;
                fetch_cc_d    = input_cc_id;
            end
        end
    end

    // WAIT keeps a private copy of the word if EXEC is stalled, so nothing is fetched twice.
    always_comb begin
        wait_word       = wait_has_data_q ? wait_instr_q : memory_data;
        wait_to_exec    = wait_valid_q && exec_free;
        wait_valid_d    = wait_valid_q && !wait_to_exec;
        wait_has_data_d = wait_has_data_q && !wait_to_exec;
        wait_instr_d    = wait_instr_q;
        wait_pc_d       = wait_pc_q;
        wait_cc_d       = wait_cc_q;
        if (wait_valid_q && !wait_to_exec && !wait_has_data_q) begin
            wait_has_data_d = 1'b1;
            wait_instr_d    = memory_data;
        end
        if (mem_hs) begin
            wait_valid_d    = 1'b1;
            wait_has_data_d = 1'b0;
            wait_pc_d       = fetch_pc_q;
            wait_cc_d       = fetch_cc_q;
        end
    end

    always_comb begin
        exec_char = '0;
        for (int i = 0; i < NCC; i++)
            if (exec_cc_q == CC_ID_BITS'(i))
                exec_char = current_characters[i*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    end

    assign exec_eos        = end_of_string[exec_cc_q];
    assign exec_op         = opcode_e'(exec_instr_q[MEMORY_WIDTH-1:INSTRUCTION_DATA_WIDTH]);
    assign exec_payload_pc = exec_instr_q[PC_WIDTH-1:0];

    always_comb begin
        exec_do_out = 1'b0;
        exec_do_acc = 1'b0;
        exec_push_n = 2'd0;
        push_pc_a   = exec_pc_q + PC_ONE;
        push_pc_b   = exec_payload_pc;
        case (exec_op)
            OP_ACCEPT:    exec_do_acc = exec_eos;
            OP_SPLIT:     exec_push_n = 2'd2;
            OP_MATCH:     exec_do_out = !exec_eos && (exec_char == exec_instr_q[CHARACTER_WIDTH-1:0]);
            OP_NOT_MATCH: exec_do_out = !exec_eos && (exec_char != exec_instr_q[CHARACTER_WIDTH-1:0]);
            OP_MATCH_ANY: exec_do_out = !exec_eos;
            OP_JMP: begin
                exec_push_n = 2'd1;
                push_pc_a   = exec_payload_pc;
            end
`ifdef REGEX_CPU_ACCEPT_PARTIAL_EN
            OP_ACCEPT_PARTIAL: exec_do_acc = 1'b1;
`endif
            default: ;
        endcase
        exec_stall = exec_valid_q &&
                     ((exec_do_out && out_valid_q && !output_pc_ready) ||
                      (int'(exec_push_n) > DEPTH - int'(fifo_cnt_q)));
        exec_fire  = exec_valid_q && !exec_stall;
        exec_free  = !exec_valid_q || exec_fire;
        push_cnt   = exec_fire ? exec_push_n : 2'd0;

        exec_valid_d = exec_valid_q && !exec_fire;
        exec_pc_d    = exec_pc_q;
        exec_cc_d    = exec_cc_q;
        exec_instr_d = exec_instr_q;
        if (wait_to_exec) begin
            exec_valid_d = 1'b1;
            exec_pc_d    = wait_pc_q;
            exec_cc_d    = wait_cc_q;
            exec_instr_d = wait_word;
        end

        out_valid_d = out_valid_q && !output_pc_ready;
        out_pc_d    = out_pc_q;
        out_cc_d    = out_cc_q;
        if (exec_fire && exec_do_out) begin
            out_valid_d = 1'b1;
            out_pc_d    = exec_pc_q + PC_ONE;
            out_cc_d    = exec_cc_q;
        end
        accepts_d = exec_fire && exec_do_acc;

        wr_ptr_d   = wr_ptr_q + FW'(push_cnt);
        rd_ptr_d   = rd_ptr_q + FW'(fifo_pop);
        fifo_cnt_d = fifo_cnt_q + (FW+1)'(push_cnt) - (FW+1)'(fifo_pop);
    end

    always_comb begin
        fifo_offs = '0;
        for (int i = 0; i < NCC; i++) begin
            elaborating_chars[i] = (fetch_valid_q && fetch_cc_q == CC_ID_BITS'(i)) ||
                                   (wait_valid_q  && wait_cc_q  == CC_ID_BITS'(i)) ||
                                   (exec_valid_q  && exec_cc_q  == CC_ID_BITS'(i)) ||
                                   (out_valid_q   && out_cc_q   == CC_ID_BITS'(i));
            for (int j = 0; j < DEPTH; j++) begin
                fifo_offs = FW'(j) - rd_ptr_q;
                if (({1'b0, fifo_offs} < fifo_cnt_q) && fifo_mem_q[j][CC_ID_BITS-1:0] == CC_ID_BITS'(i))
                    elaborating_chars[i] = 1'b1;
            end
        end
        running = fetch_valid_q || wait_valid_q || exec_valid_q || out_valid_q || (fifo_cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (exec_fire && exec_push_n != 2'd0) fifo_mem_q[wr_ptr_q] <= {push_pc_a, exec_cc_q};
        if (exec_fire && exec_push_n == 2'd2) fifo_mem_q[wr_ptr_q + PTR_ONE] <= {push_pc_b, exec_cc_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q      <= 1'b0;
            fetch_valid_q   <= 1'b0;
            fetch_pc_q      <= '0;
            fetch_cc_q      <= '0;
            wait_valid_q    <= 1'b0;
            wait_has_data_q <= 1'b0;
            wait_pc_q       <= '0;
            wait_cc_q       <= '0;
            wait_instr_q    <= '0;
            exec_valid_q    <= 1'b0;
            exec_pc_q       <= '0;
            exec_cc_q       <= '0;
            exec_instr_q    <= '0;
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_cc_q        <= '0;
            accepts_q       <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fifo_cnt_q      <= '0;
        end else begin
            ready_en_q      <= ready_en_d;
            fetch_valid_q   <= fetch_valid_d;
            fetch_pc_q      <= fetch_pc_d;
            fetch_cc_q      <= fetch_cc_d;
            wait_valid_q    <= wait_valid_d;
            wait_has_data_q <= wait_has_data_d;
            wait_pc_q       <= wait_pc_d;
            wait_cc_q       <= wait_cc_d;
            wait_instr_q    <= wait_instr_d;
            exec_valid_q    <= exec_valid_d;
            exec_pc_q       <= exec_pc_d;
            exec_cc_q       <= exec_cc_d;
            exec_instr_q    <= exec_instr_d;
            out_valid_q     <= out_valid_d;
            out_pc_q        <= out_pc_d;
            out_cc_q        <= out_cc_d;
            accepts_q       <= accepts_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fifo_cnt_q      <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_regex_cpu_pipe.sv
// Directed bench for regex_cpu_pipe: behavioural instruction memory, output/accept monitor, hand-computed checks.
module tb_regex_cpu_pipe;
    localparam logic [2:0] OP_ACCEPT = 3'd0, OP_SPLIT = 3'd1, OP_MATCH = 3'd2, OP_NOT_MATCH = 3'd3,
                           OP_MATCH_ANY = 3'd4, OP_JMP = 3'd5, OP_END = 3'd6, OP_ACCEPT_PARTIAL = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string;
    logic        input_pc_valid, input_pc_ready;
    logic [8:0]  input_pc;
    logic [1:0]  input_cc_id;
    logic        memory_valid, memory_ready;
    logic [10:0] memory_addr;
    logic [19:0] memory_data;
    logic        output_pc_valid, output_pc_ready;
    logic [8:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts;
    logic [3:0]  elaborating_chars;
    logic        running;

    always #5 clk = ~clk;

    regex_cpu_pipe dut (
        .clk(clk), .rst(rst), .current_characters(current_characters), .end_of_string(end_of_string),
        .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready), .input_pc(input_pc),
        .input_cc_id(input_cc_id), .memory_valid(memory_valid), .memory_ready(memory_ready),
        .memory_addr(memory_addr), .memory_data(memory_data), .output_pc_valid(output_pc_valid),
        .output_pc_ready(output_pc_ready), .output_pc(output_pc), .output_cc_id(output_cc_id),
        .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
    );

    logic [19:0] mem [0:2047];
    logic        pend = 1'b0;
    logic [10:0] pend_addr = '0;
    logic [8:0]  out_pcs [$];
    logic [1:0]  out_ccs [$];
    int          acc_cnt = 0;
    int          n_total = 0, n_bad = 0;

    // Word appears only in the cycle after the fetch handshake; otherwise a junk word is driven.
    always @(negedge clk) begin
        memory_data = pend ? mem[pend_addr] : 20'hFFFFF;
        pend        = memory_valid && memory_ready;
        pend_addr   = memory_addr;
        if (output_pc_valid && output_pc_ready) begin
            out_pcs.push_back(output_pc);
            out_ccs.push_back(output_cc_id);
        end
        if (accepts) acc_cnt++;
    end

    function automatic logic [19:0] ins(input logic [2:0] op, input int unsigned pay);
        return {op, 17'(pay)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int pc, input int cc);
        int t = 0;
        input_pc       = 9'(pc);
        input_cc_id    = 2'(cc);
        input_pc_valid = 1'b1;
        while (!input_pc_ready && t < 60) begin
            step();
            t++;
        end
        if (!input_pc_ready) chk("send_ready_timeout", 32'(input_pc_ready), 1);
        step();
        input_pc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (running && t < budget) begin
            step();
            t++;
        end
        if (running) chk("idle_timeout", 32'(running), 0);
        step();
        step();
    endtask

    task automatic clear_log();
        out_pcs.delete();
        out_ccs.delete();
        acc_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        current_characters = '0;
        end_of_string = '0;
        input_pc_valid = 1'b0;
        input_pc = '0;
        input_cc_id = '0;
        memory_ready = 1'b1;
        output_pc_ready = 1'b1;
        for (int a = 0; a < 2048; a++) mem[a] = ins(OP_END, 0);
        repeat (3) step();

        chk("rst_in_ready", 32'(input_pc_ready), 0);
        chk("rst_mem_valid", 32'(memory_valid), 0);
        chk("rst_out_valid", 32'(output_pc_valid), 0);
        chk("rst_accepts", 32'(accepts), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_elab", 32'(elaborating_chars), 0);
        rst = 1'b1;
        chk("ready_before_edge", 32'(input_pc_ready), 0);
        step();
        chk("ready_after_release", 32'(input_pc_ready), 1);

        // fetch handshake, memory_ready one cycle late
        mem[220] = ins(OP_END, 0);
        memory_ready = 1'b0;
        send(220, 1);
        chk("fetch_valid", 32'(memory_valid), 1);
        chk("fetch_addr", 32'(memory_addr), 220);
        chk("fetch_in_ready", 32'(input_pc_ready), 0);
        chk("fetch_elab", 32'(elaborating_chars), 4'b0010);
        memory_ready = 1'b1;
        step();
        chk("hs_valid_drop", 32'(memory_valid), 0);
        chk("hs_elab1", 32'(elaborating_chars[1]), 1);
        wait_idle(20);

        // END_WITHOUT_ACCEPTING sweep
        clear_log();
        for (int k = 0; k < 74; k++) mem[220 + k] = ins(OP_END, k % 11);
        for (int k = 0; k < 74; k++) begin
            current_characters = {4{8'(k % 64)}};
            send(220 + k, k % 4);
        end
        wait_idle(100);
        chk("end_outputs", 32'(out_pcs.size()), 0);
        chk("end_accepts", 32'(acc_cnt), 0);
        chk("end_running", 32'(running), 0);

        // MATCH hit with latency check, then miss
        mem[5] = ins(OP_MATCH, 8'h61);
        current_characters = {8'h00, 8'h61, 8'h00, 8'h00};
        end_of_string = '0;
        clear_log();
        send(5, 2);
        step();
        step();
        chk("match_early", 32'(output_pc_valid), 0);
        step();
        chk("match_valid", 32'(output_pc_valid), 1);
        chk("match_pc", 32'(output_pc), 6);
        chk("match_cc", 32'(output_cc_id), 2);
        wait_idle(20);
        chk("match_count", 32'(out_pcs.size()), 1);
        current_characters = {8'h00, 8'h62, 8'h00, 8'h00};
        clear_log();
        send(5, 2);
        wait_idle(20);
        chk("match_miss", 32'(out_pcs.size()), 0);

        // ACCEPT with and without end of string
        mem[30] = ins(OP_ACCEPT, 0);
        end_of_string = 4'b0001;
        clear_log();
        send(30, 0);
        wait_idle(20);
        chk("accept_eos", 32'(acc_cnt), 1);
        end_of_string = 4'b0000;
        clear_log();
        send(30, 0);
        wait_idle(20);
        chk("accept_no_eos", 32'(acc_cnt), 0);

        // NOT_MATCH
        mem[50] = ins(OP_NOT_MATCH, 8'h78);
        current_characters = {8'h79, 24'h0};
        clear_log();
        send(50, 3);
        wait_idle(20);
        chk("nm_count", 32'(out_pcs.size()), 1);
        chk("nm_pc", 32'(out_pcs[0]), 51);
        chk("nm_cc", 32'(out_ccs[0]), 3);
        current_characters = {8'h78, 24'h0};
        clear_log();
        send(50, 3);
        wait_idle(20);
        chk("nm_equal", 32'(out_pcs.size()), 0);
        current_characters = {8'h79, 24'h0};
        end_of_string = 4'b1000;
        clear_log();
        send(50, 3);
        wait_idle(20);
        chk("nm_eos", 32'(out_pcs.size()), 0);

        // MATCH_ANY with/without eos, JMP
        mem[70] = ins(OP_MATCH_ANY, 0);
        end_of_string = 4'b0100;
        clear_log();
        send(70, 2);
        wait_idle(20);
        chk("any_eos", 32'(out_pcs.size()), 0);
        end_of_string = 4'b0000;
        clear_log();
        send(70, 2);
        wait_idle(20);
        chk("any_pc", 32'(out_pcs[0]), 71);
        mem[80] = ins(OP_JMP, 90);
        mem[90] = ins(OP_MATCH_ANY, 0);
        clear_log();
        send(80, 1);
        wait_idle(30);
        chk("jmp_count", 32'(out_pcs.size()), 1);
        chk("jmp_pc", 32'(out_pcs[0]), 91);

        // ACCEPT_PARTIAL depends on build
        mem[60] = ins(OP_ACCEPT_PARTIAL, 0);
        clear_log();
        send(60, 0);
        wait_idle(20);
`ifdef REGEX_CPU_ACCEPT_PARTIAL_EN
        chk("partial_accepts", 32'(acc_cnt), 1);
`else
        chk("partial_accepts", 32'(acc_cnt), 0);
`endif
        chk("partial_outputs", 32'(out_pcs.size()), 0);

        // SPLIT with output back-pressure
        mem[10] = ins(OP_SPLIT, 40);
        mem[11] = ins(OP_MATCH_ANY, 0);
        mem[40] = ins(OP_MATCH_ANY, 0);
        output_pc_ready = 1'b0;
        clear_log();
        send(10, 1);
        for (int t = 0; t < 40 && !output_pc_valid; t++) step();
        if (!output_pc_valid) chk("split_out_timeout", 32'(output_pc_valid), 1);
        repeat (5) step();
        chk("split_hold_valid", 32'(output_pc_valid), 1);
        chk("split_hold_pc", 32'(output_pc), 12);
        chk("split_running", 32'(running), 1);
        output_pc_ready = 1'b1;
        wait_idle(40);
        chk("split_count", 32'(out_pcs.size()), 2);
        chk("split_first", 32'(out_pcs[0]), 12);
        chk("split_second", 32'(out_pcs[1]), 41);
        chk("split_cc0", 32'(out_ccs[0]), 1);
        chk("split_cc1", 32'(out_ccs[1]), 1);

        // reset while a thread sits in WAIT
        clear_log();
        send(70, 2);
        step();
        chk("wait_running", 32'(running), 1);
        rst = 1'b0;
        #1;
        chk("midrst_running", 32'(running), 0);
        chk("midrst_mem_valid", 32'(memory_valid), 0);
        chk("midrst_out_valid", 32'(output_pc_valid), 0);
        chk("midrst_elab", 32'(elaborating_chars), 0);
        chk("midrst_in_ready", 32'(input_pc_ready), 0);
        step();
        rst = 1'b1;
        step();
        wait_idle(10);
        chk("midrst_no_output", 32'(out_pcs.size()), 0);
        chk("midrst_ready_back", 32'(input_pc_ready), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
